// File: rtl/crc4_pkg.sv
// Shared CRC-4 definitions for the serial generator and checker: polynomial,
// checker FSM encoding and the single-bit Galois LFSR step.
package crc4_pkg;

  localparam int         CRC_W = 4;
  localparam logic [4:0] G     = 5'b11001;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DATA = 2'd1;
  localparam logic [1:0] ST_CRC  = 2'd2;

  // One shift of the Galois LFSR: fb = d ^ r[3]; fb is folded in at the x^3 and x^0 taps.
  function automatic logic [CRC_W-1:0] crc4_step(input logic [CRC_W-1:0] r, input logic d);
    logic fb;
    fb = d ^ r[CRC_W-1];
    return {r[CRC_W-2:0], 1'b0} ^ (fb ? G[CRC_W-1:0] : '0);
  endfunction

endpackage

// File: rtl/crc4_chk_if.sv
// Serial payload/CRC input stream and verdict outputs of the CRC-4 checker.
// The syndrome signal exists only when CRC4_CHK_SYNDROME_EN is defined.
interface crc4_chk_if #(parameter int LEN_W = 16);

  logic             crc_start;
  logic             data;
  logic             data_valid;
  logic             crc_in;
  logic             crc_in_valid;
  logic             busy;
  logic             chk_done;
  logic             chk_ok;
  logic             chk_err;
  logic [LEN_W-1:0] payload_len;
`ifdef CRC4_CHK_SYNDROME_EN
  logic [3:0]       syndrome;

  modport master (output crc_start, data, data_valid, crc_in, crc_in_valid,
                  input  busy, chk_done, chk_ok, chk_err, payload_len, syndrome);
  modport slave  (input  crc_start, data, data_valid, crc_in, crc_in_valid,
                  output busy, chk_done, chk_ok, chk_err, payload_len, syndrome);
`else
  modport master (output crc_start, data, data_valid, crc_in, crc_in_valid,
                  input  busy, chk_done, chk_ok, chk_err, payload_len);
  modport slave  (input  crc_start, data, data_valid, crc_in, crc_in_valid,
                  output busy, chk_done, chk_ok, chk_err, payload_len);
`endif

endinterface

// File: rtl/crc4_lfsr.sv
// 4-bit CRC register with synchronous clear and shift-enable around crc4_step.
module crc4_lfsr
  import crc4_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_shift,
  input  logic             i_d,
  output logic [CRC_W-1:0] o_crc
);

  logic [CRC_W-1:0] r_crc;

  // NOTE: state is updated with non-blocking assignments and reset synchronously
  // so every register in the checker samples the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_crc <= '0;
    end else if (i_shift) begin
      r_crc <= crc4_step(r_crc, i_d);
    end
  end

  assign o_crc = r_crc;

endmodule

// File: rtl/crc4_chk.sv
// Serial CRC-4 checker: recomputes the payload CRC and compares it with the
// trailing 4 received bits. Optional syndrome output: CRC4_CHK_SYNDROME_EN.
module crc4_chk
  import crc4_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic       clk,
  input  logic       rst,
  crc4_chk_if.slave  bus
);

  logic [1:0]       r_state;
  logic [1:0]       r_crc_cnt;
  logic             r_err;
  logic             r_chk_done;
  logic             r_chk_ok;
  logic             r_chk_err;
  logic [LEN_W-1:0] r_payload_len;

  logic [CRC_W-1:0] w_crc;
  logic             w_shift;
  logic             w_exp_bit;
  logic             w_mismatch;
  logic             w_violation;
  logic             w_last;

  crc4_lfsr u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (bus.crc_start),
    .i_shift (w_shift),
    .i_d     (bus.data),
    .o_crc   (w_crc)
  );

  // r_crc_cnt is 0 throughout DATA, so the first CRC bit compares against r[3].
  assign w_exp_bit   = w_crc[2'd3 - r_crc_cnt];
  assign w_mismatch  = bus.crc_in ^ w_exp_bit;
  assign w_last      = (r_state == ST_CRC) && (r_crc_cnt == 2'd3);
  assign w_shift     = (r_state == ST_DATA) && bus.data_valid && !bus.crc_in_valid;
  assign w_violation = ((r_state == ST_DATA) && bus.data_valid && bus.crc_in_valid) ||
                       ((r_state == ST_CRC)  && bus.data_valid);

`ifdef CRC4_CHK_SYNDROME_EN
  logic [CRC_W-1:0] r_syn_acc;
  logic [CRC_W-1:0] r_syndrome;

  // Working accumulator fills MSB first; the published value only moves on a verdict.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_syn_acc  <= '0;
      r_syndrome <= '0;
    end else if (bus.crc_start) begin
      r_syn_acc <= '0;
    end else if (w_violation) begin
      r_syndrome <= '1;
    end else if ((r_state != ST_IDLE) && bus.crc_in_valid) begin
      r_syn_acc[2'd3 - r_crc_cnt] <= w_mismatch;
      if (w_last) r_syndrome <= {r_syn_acc[3:1], w_mismatch};
    end
  end

  assign bus.syndrome = r_syndrome;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_crc_cnt     <= '0;
      r_err         <= 1'b0;
      r_chk_done    <= 1'b0;
      r_chk_ok      <= 1'b0;
      r_chk_err     <= 1'b0;
      r_payload_len <= '0;
    end else begin
      r_chk_done <= 1'b0;
      if (bus.crc_start) begin
        r_state       <= ST_DATA;
        r_crc_cnt     <= '0;
        r_err         <= 1'b0;
        r_payload_len <= '0;
      end else if (w_violation) begin
        r_state    <= ST_IDLE;
        r_chk_done <= 1'b1;
        r_chk_ok   <= 1'b0;
        r_chk_err  <= 1'b1;
      end else if ((r_state != ST_IDLE) && bus.crc_in_valid) begin
        r_err <= r_err | w_mismatch;
        if (w_last) begin
          r_state    <= ST_IDLE;
          r_chk_done <= 1'b1;
          r_chk_ok   <= !(r_err | w_mismatch);
          r_chk_err  <= r_err | w_mismatch;
        end else begin
          r_state   <= ST_CRC;
          r_crc_cnt <= r_crc_cnt + 2'd1;
        end
      end else if (w_shift && (r_payload_len != '1)) begin
        r_payload_len <= r_payload_len + 1'b1;
      end
    end
  end

  assign bus.busy        = (r_state != ST_IDLE);
  assign bus.chk_done    = r_chk_done;
  assign bus.chk_ok      = r_chk_ok;
  assign bus.chk_err     = r_chk_err;
  assign bus.payload_len = r_payload_len;

endmodule

// File: tb/tb_crc4_chk.sv
// Self-checking bench for crc4_chk: directed frames from the test plan plus
// random frames checked against a polynomial long-division reference.
module tb_crc4_chk;

  localparam int         LEN_W = 16;
  localparam logic [4:0] POLY  = 5'b11001;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  crc4_chk_if #(.LEN_W(LEN_W)) bus ();
  crc4_chk #(.LEN_W(LEN_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_vec     = 0;
  int n_err     = 0;
  int done_seen = 0;

  always @(negedge clk) if (bus.chk_done === 1'b1) done_seen++;

  // Remainder of M(x)*x^4 divided by G(x), by plain long division.
  function automatic logic [3:0] ref_crc(input bit msg[$]);
    logic [4:0] rem = '0;
    for (int i = 0; i < msg.size() + 4; i++) begin
      rem = {rem[3:0], (i < msg.size()) ? msg[i] : 1'b0};
      if (rem[4]) rem = rem ^ POLY;
    end
    return rem[3:0];
  endfunction

  function automatic logic [31:0] exp_len(input int n);
    return (n >= (2 ** LEN_W) - 1) ? (2 ** LEN_W) - 1 : n;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic s, input logic d, input logic dv,
                       input logic c, input logic cv);
    @(negedge clk);
    bus.crc_start    = s;
    bus.data         = d;
    bus.data_valid   = dv;
    bus.crc_in       = c;
    bus.crc_in_valid = cv;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic start_frame();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_body(input bit msg[$], input logic [3:0] crc, input int gap);
    for (int i = 0; i < msg.size(); i++) begin
      repeat ($urandom_range(0, gap)) idle();
      drive(1'b0, msg[i], 1'b1, 1'b0, 1'b0);
    end
    for (int k = 3; k >= 0; k--) begin
      repeat ($urandom_range(0, gap)) idle();
      drive(1'b0, 1'b0, 1'b0, crc[k], 1'b1);
    end
  endtask

  task automatic check_verdict(input string tag, input logic ok, input logic [31:0] len,
                               input logic [3:0] syn);
    check({tag, ".done"}, 32'(bus.chk_done), 32'd1);
    check({tag, ".ok"},   32'(bus.chk_ok),   32'(ok));
    check({tag, ".err"},  32'(bus.chk_err),  32'(!ok));
    check({tag, ".busy"}, 32'(bus.busy),     32'd0);
    check({tag, ".len"},  32'(bus.payload_len), len);
`ifdef CRC4_CHK_SYNDROME_EN
    check({tag, ".syn"},  32'(bus.syndrome), 32'(syn));
`else
    if (syn != syn) n_vec++;
`endif
  endtask

  initial begin
    bit         msg[$];
    logic [3:0] crc_good;
    logic [3:0] crc_rx;
    int         snap;

    rst = 1'b1;
    bus.crc_start = 1'b0; bus.data = 1'b0; bus.data_valid = 1'b0;
    bus.crc_in = 1'b0; bus.crc_in_valid = 1'b0;
    idle(); idle();
    check("rst.busy", 32'(bus.busy), 32'd0);
    check("rst.done", 32'(bus.chk_done), 32'd0);
    check("rst.ok",   32'(bus.chk_ok), 32'd0);
    check("rst.err",  32'(bus.chk_err), 32'd0);
    check("rst.len",  32'(bus.payload_len), 32'd0);
`ifdef CRC4_CHK_SYNDROME_EN
    check("rst.syn",  32'(bus.syndrome), 32'd0);
`endif
    rst = 1'b0;

    // Single-bit payload, CRC 1001.
    start_frame(); idle();
    check("p1.busy", 32'(bus.busy), 32'd1);
    msg = '{1'b1};
    check("p1.ref", 32'(ref_crc(msg)), 32'h9);
    send_body(msg, 4'b1001, 0);
    idle();
    check_verdict("p1", 1'b1, 32'd1, 4'b0000);

    // Payload 1010: correct CRC, then one flipped CRC bit.
    msg = '{1'b1, 1'b0, 1'b1, 1'b0};
    start_frame(); send_body(msg, 4'b1100, 0); idle();
    check_verdict("p1010_ok", 1'b1, 32'd4, 4'b0000);
    start_frame(); send_body(msg, 4'b1101, 0); idle();
    check_verdict("p1010_bad", 1'b0, 32'd4, 4'b0001);

    // Zero-length payload with gaps.
    msg = {};
    start_frame(); send_body(msg, 4'b0000, 3); idle();
    check_verdict("zero", 1'b1, 32'd0, 4'b0000);

    // Valids in IDLE are ignored; held verdict unchanged.
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle();
    check("idle_ign.busy", 32'(bus.busy), 32'd0);
    check("idle_ign.done", 32'(bus.chk_done), 32'd0);
    check("idle_ign.ok",   32'(bus.chk_ok), 32'd1);
    check("idle_ign.len",  32'(bus.payload_len), 32'd0);

    // Protocol violation: both valids in DATA.
    start_frame();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    idle();
    check_verdict("viol", 1'b0, 32'd1, 4'b1111);

    // Restart mid-payload, then a clean frame: exactly one verdict.
    idle();
    snap = done_seen;
    start_frame();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    start_frame();
    msg = '{1'b1};
    send_body(msg, 4'b1001, 2); idle();
    check_verdict("restart", 1'b1, 32'd1, 4'b0000);
    idle(); idle();
    check("restart.n_done", 32'(done_seen - snap), 32'd1);

    // Reset mid-frame discards the frame.
    snap = done_seen;
    start_frame();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    rst = 1'b1;
    idle();
    rst = 1'b0;
    check("rstmid.busy", 32'(bus.busy), 32'd0);
    check("rstmid.ok",   32'(bus.chk_ok), 32'd0);
    check("rstmid.err",  32'(bus.chk_err), 32'd0);
    check("rstmid.len",  32'(bus.payload_len), 32'd0);
`ifdef CRC4_CHK_SYNDROME_EN
    check("rstmid.syn",  32'(bus.syndrome), 32'd0);
`endif
    idle(); idle(); idle(); idle();
    check("rstmid.n_done", 32'(done_seen - snap), 32'd0);

    // Random frames with gaps, some corrupted, some back-to-back.
    start_frame();
    for (int f = 0; f < 30; f++) begin
      msg = {};
      repeat ($urandom_range(0, 20)) msg.push_back(bit'($urandom_range(0, 1)));
      crc_good = ref_crc(msg);
      crc_rx   = crc_good;
      if ($urandom_range(0, 1) == 1) crc_rx = crc_rx ^ 4'($urandom_range(1, 15));
      send_body(msg, crc_rx, 3);
      if ($urandom_range(0, 1) == 1) begin
        start_frame();
        check_verdict($sformatf("rnd%0d", f), crc_rx == crc_good, exp_len(msg.size()),
                      crc_rx ^ crc_good);
      end else begin
        idle();
        check_verdict($sformatf("rnd%0d", f), crc_rx == crc_good, exp_len(msg.size()),
                      crc_rx ^ crc_good);
        start_frame();
      end
    end

    // 2^LEN_W + 3 payload bits: payload_len saturates.
    msg = {};
    repeat ((2 ** LEN_W) + 3) msg.push_back(bit'($urandom_range(0, 1)));
    crc_good = ref_crc(msg);
    start_frame(); send_body(msg, crc_good, 0); idle();
    check_verdict("sat", 1'b1, exp_len(msg.size()), 4'b0000);

    idle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/crc4_chk.md
# crc4_chk

Serial CRC-4 checker, receive-side counterpart of the crc4 serial generator. It recomputes the CRC over a serial payload with polynomial G(x)=x^4+x^3+1 (5'b11001) and compares the result against the 4 CRC bits that follow the payload. After each frame it reports pass or fail. It sits after the serial deserialising front end and feeds frame-accept logic.

## Interface
- LEN_W, 16: width of the payload bit counter.
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  synchronous reset, active-high.
- crc_start  in  1  one-cycle frame-start pulse; clears all frame state.
- data  in  1  payload bit, MSB of message first.
- data_valid  in  1  data is a payload bit this cycle.
- crc_in  in  1  received CRC bit, CRC[3] first.
- crc_in_valid  in  1  crc_in is a CRC bit this cycle.
- busy  out  1  frame in progress (state DATA or CRC).
- chk_done  out  1  one-cycle pulse: frame verdict is valid.
- chk_ok  out  1  last frame passed; held.
- chk_err  out  1  last frame failed (mismatch or protocol error); held.
- payload_len  out  LEN_W  payload bits in last/current frame; saturates at all-ones.

## Operation
- Reference LFSR r[3:0] has Galois form with fb = d ^ r[3]:
  - r0<=fb; r1<=r0; r2<=r1; r3<=r2^fb.
  - It computes M(x)·x^4 mod G.
- FSM states:
  - IDLE: crc_start -> DATA. Clears r, bit/CRC counters, err accumulator and payload_len. Does not clear chk_ok/chk_err.
  - DATA: data_valid -> shift one bit and increment payload_len. First crc_in_valid -> compare crc_in with r[3]; crc_cnt=1; -> CRC.
  - CRC: each crc_in_valid compares crc_in with r[3-crc_cnt] and ORs any mismatch into err. After the 4th CRC bit -> IDLE, pulse chk_done, set chk_ok=!err and chk_err=err.
- r is frozen once the CRC phase begins.
- Zero-length payload is legal: the expected CRC is 4'b0000.
- Protocol violations abort the frame: -> IDLE, pulse chk_done, chk_ok=0, chk_err=1. Violations are:
  - data_valid and crc_in_valid both high in DATA or CRC;
  - data_valid in CRC.
- data_valid and crc_in_valid in IDLE are ignored. No outputs change.
- crc_start in any state restarts the frame. Both valids are ignored in that cycle, and no verdict is issued for the aborted frame.
- Gaps (both valids low) are allowed anywhere inside a frame.

## Timing
- Reset values: state IDLE, r=0, busy=0, chk_done=0, chk_ok=0, chk_err=0, payload_len=0.
- busy is high from the cycle after crc_start until the cycle chk_done is high (inclusive of the DATA/CRC cycles, exclusive of the chk_done cycle).
- Verdict latency: chk_done, chk_ok and chk_err update on the edge that samples the 4th crc_in_valid. They are visible in the following cycle.
- A crc_start in the cycle after chk_done is accepted normally. Back-to-back frames need no idle gap.
- rst mid-frame discards the frame; no chk_done is issued.

## Configuration
- CRC4_CHK_SYNDROME_EN defined:
  - Adds output `syndrome[3:0]` = computed CRC XOR received CRC, accumulated bit by bit.
  - syndrome is valid with chk_done and held until the next verdict.
  - Reset value 0.
  - On a protocol abort it reads 4'b1111.
- CRC4_CHK_SYNDROME_EN undefined: the port and its logic are absent. All other behaviour is identical.

## Structure
- crc4_pkg holds:
  - CRC_W=4;
  - G=5'b11001;
  - the FSM state encoding (IDLE, DATA, CRC);
  - a function for one LFSR step.
- The crc4_pkg is shared with the crc4 generator.
- One sub-module, crc4_lfsr: holds the 4-bit register with clear and shift-enable, wrapping the package step function. The top holds the FSM, counters and compare.

## Test plan
- Payload 1'b1, then CRC 1,0,0,1 -> chk_done one cycle after the last CRC bit, chk_ok=1, payload_len=1.
- Payload 1,0,1,0, then CRC 1,1,0,0 -> chk_ok=1. Same payload with CRC 1,1,0,1 -> chk_err=1; syndrome=4'b0001 when CRC4_CHK_SYNDROME_EN is defined.
- crc_start then immediately CRC 0,0,0,0 -> chk_ok=1, payload_len=0. Random idle gaps between bits do not change either result.
- data_valid and crc_in_valid both high in DATA -> chk_done next cycle, chk_err=1, busy=0; syndrome=4'b1111 when enabled.
- Second crc_start mid-payload, then a clean frame 1 / 1,0,0,1 -> exactly one chk_done, chk_ok=1. rst mid-frame -> no chk_done, all outputs 0.
- 2^LEN_W+3 payload bits with the matching CRC -> payload_len saturates at all-ones, chk_ok=1.
